// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and helpers for the BCD occupancy counter.
//   bcd_digit_t  - one decade (4 bits, 0..9)
//   bcd_vec_t    - packed BCD vector sized for the widest supported count
//   to_bcd()     - constant-foldable binary -> packed BCD conversion
package bcd_pkg;

  localparam int MAX_DIGITS = 4;

  typedef logic [3:0]              bcd_digit_t;
  typedef logic [4*MAX_DIGITS-1:0] bcd_vec_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Digit 0 lands in bits [3:0]; decades above 'digits' stay zero.
  function automatic bcd_vec_t to_bcd(input int value, input int digits);
    bcd_vec_t r;
    int       v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        r[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD decade of the occupancy counter.
//   clk        - rising-edge clock
//   ld         - synchronous load (clear / wrap), overrides en
//   ld_val     - value taken on ld
//   en         - step this decade by one
//   up         - step direction, 1 = increment, 0 = decrement
//   digit      - registered decade value, always 0..9
//   carry_out  - en & up & digit==9  (combinational, feeds next en)
//   borrow_out - en & ~up & digit==0 (combinational, feeds next en)
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  input  logic       en,
  input  logic       up,
  output bcd_digit_t digit,
  output logic       carry_out,
  output logic       borrow_out
);

  bcd_digit_t digit_q, digit_d;

  assign carry_out  = en &  up & (digit_q == BCD_MAX);
  assign borrow_out = en & ~up & (digit_q == BCD_MIN);

  always_comb begin
    digit_d = digit_q;
    if (ld) begin
      digit_d = ld_val;
    end else if (en) begin
      if (up) digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      else    digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk) digit_q <= digit_d;

  assign digit = digit_q;

endmodule

// File: rtl/bcd_occupancy_counter.sv
// bcd_occupancy_counter: bounded multi-decade BCD up/down occupancy count.
//   clk     - rising-edge clock
//   reset   - synchronous active-high reset
//   clr     - synchronous clear, same effect as reset
//   incr    - vehicle-entered pulse
//   decr    - vehicle-exited pulse
//   bcd     - registered count, digit 0 in [3:0]
//   full    - count == CAPACITY
//   empty   - count == 0
//   ovf_err - sticky, incr seen while full
//   unf_err - sticky, decr seen while empty
// Build option: define BCDCNT_WRAP_EN to wrap at the bounds (full->0,
// empty->CAPACITY) instead of saturating; error flags are set either way.
module bcd_occupancy_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int CAPACITY = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                incr,
  input  logic                decr,
  output logic [4*DIGITS-1:0] bcd,
  output logic                full,
  output logic                empty,
  output logic                ovf_err,
  output logic                unf_err
);

  if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("bcd_occupancy_counter: DIGITS must be 1..4");
  end
  if (CAPACITY < 1 || CAPACITY > 10**DIGITS - 1) begin : g_bad_cap
    $error("bcd_occupancy_counter: CAPACITY out of range for DIGITS");
  end

  localparam bcd_vec_t            CAP_BCD_ALL = to_bcd(CAPACITY, DIGITS);
  localparam logic [4*DIGITS-1:0] CAP_BCD     = CAP_BCD_ALL[4*DIGITS-1:0];

  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS:0]     en_chain;
  logic [DIGITS-1:0]   carry, borrow;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                tick, sign, clear;
  logic                refuse_up, refuse_dn;
  logic                ld;
  logic [4*DIGITS-1:0] ld_val;

  // Flags decode straight from registered digits, so they line up with bcd.
  assign full  = (bcd_q == CAP_BCD);
  assign empty = (bcd_q == '0);

  always_comb begin
    tick        = incr ^ decr;       // both high cancels
    sign        = incr;
    clear       = reset | clr;
    refuse_up   = tick &  sign & full;
    refuse_dn   = tick & ~sign & empty;
    en_chain[0] = tick & ~refuse_up & ~refuse_dn & ~clear;
    ld          = clear;
    ld_val      = '0;
`ifdef BCDCNT_WRAP_EN
    if (!clear && refuse_up) begin
      ld     = 1'b1;
      ld_val = '0;
    end else if (!clear && refuse_dn) begin
      ld     = 1'b1;
      ld_val = CAP_BCD;
    end
`endif
    ovf_d = clear ? 1'b0 : (ovf_q | refuse_up);
    unf_d = clear ? 1'b0 : (unf_q | refuse_dn);
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_digit (
      .clk       (clk),
      .ld        (ld),
      .ld_val    (ld_val[4*g +: 4]),
      .en        (en_chain[g]),
      .up        (sign),
      .digit     (bcd_q[4*g +: 4]),
      .carry_out (carry[g]),
      .borrow_out(borrow[g])
    );
    // Ripple: a decade rolling over steps the next one in the same cycle.
    assign en_chain[g+1] = carry[g] | borrow[g];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bcd     = bcd_q;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: doc/bcd_occupancy_counter.md
Name: bcd_occupancy_counter

Overview:
- Parametrised multi-digit BCD up/down counter for the parking-lot occupancy path.
- Sits between the entry/exit FSM and the 7-segment display driver.
- Takes single-cycle incr/decr event pulses and keeps a registered BCD count bounded to [0, CAPACITY].
- Adds full/empty flags, sticky over/underflow error flags, simultaneous-event cancellation and a synchronous clear.

Parameters:
- DIGITS, 2, number of BCD decades in the count (1..4).
- CAPACITY, 25, maximum count in binary; must satisfy 1 <= CAPACITY <= 10**DIGITS-1 (elaboration-time assertion).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- clr  input  1  synchronous count clear; same effect as reset on all state.
- incr  input  1  vehicle-entered pulse from FSM, one cycle per event.
- decr  input  1  vehicle-exited pulse from FSM, one cycle per event.
- bcd  output  4*DIGITS  registered count; digit 0 in bits [3:0], LS decade first.
- full  output  1  count == CAPACITY.
- empty  output  1  count == 0.
- ovf_err  output  1  sticky: incr was refused while full.
- unf_err  output  1  sticky: decr was refused while empty.

Behaviour:
- Reset/clr values: bcd = 0 (all digits 0), empty = 1, full = 0, ovf_err = 0, unf_err = 0.
- Reset or clr has priority over any incr/decr in the same cycle.
- Internal decode each cycle: tick = incr XOR decr; sign = incr (1 = up, 0 = down).
- incr and decr both high: net zero; count, flags and errors unchanged.
- Latency: an accepted event updates bcd on the next rising edge. full/empty are decoded from registered state, so they are valid in the same cycle as bcd.
- Up step with full = 0: digit 0 increments; a digit at 9 goes to 0 and carries into the next digit; the ripple is combinational within one cycle.
- Down step with empty = 0: digit 0 decrements; a digit at 0 goes to 9 and borrows from the next digit.
- Up step while full: count holds; ovf_err is set on the next edge.
- Down step while empty: count holds; unf_err is set on the next edge.
- ovf_err and unf_err clear only on reset or clr.
- No digit ever holds a value above 9, and count never exceeds CAPACITY.
- full compares against CAPACITY converted to BCD by a constant function in the package; no binary shadow counter is kept.
- Back-to-back pulses on consecutive cycles are each counted. No input pulse is lost or merged.

Optional Feature:
- Macro: BCDCNT_WRAP_EN.
- Defined:
  - incr while full wraps the count to 0 (empty = 1 next cycle).
  - decr while empty wraps the count to CAPACITY.
  - ovf_err/unf_err are still set on the wrap event.
- Undefined: saturating behaviour as above.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0]).
  - constants BCD_MAX = 4'd9, BCD_MIN = 4'd0.
  - function to_bcd(int value, int digits) returning the packed BCD vector.
- Sub-module bcd_digit: one decade with inputs en, up, ld_val and outputs digit, carry_out/borrow_out (combinational, asserted when en and the digit is at 9 going up or 0 going down).
- Top instantiates DIGITS copies via generate, chaining carry/borrow into the next stage's en.
- Top holds the tick/sign decode, saturation/wrap control, flag logic and clr/reset priority.

Test Plan (DIGITS=2, CAPACITY=25):
- Reset, then 9 incr pulses then 1 more -> bcd 0x09 then 0x10 one cycle after the 10th pulse; empty drops after the first pulse.
- 25 back-to-back incr pulses from 0 -> bcd 0x25 and full = 1; a 26th incr -> bcd stays 0x25 and ovf_err = 1 (with BCDCNT_WRAP_EN: bcd 0x00, empty = 1, ovf_err = 1).
- From 0x10, one decr -> 0x09. From 0x00, decr -> bcd 0x00 and unf_err = 1 (wrap build: bcd 0x25).
- From 0x12, incr and decr high together for 3 cycles -> bcd stays 0x12 and no flags change.
- From 0x20 with ovf_err set, assert clr together with incr -> next cycle bcd 0x00, empty = 1, ovf_err = 0; the same with reset gives an identical result.
- Random incr/decr stream of 2000 cycles against a saturating integer model -> bcd matches to_bcd(model), digits <= 9, full/empty consistent every cycle.
